// File: rtl/flappy_collide.sv
// Collision and game-over detector: tests the bird box against the active pipe
// gap and the floor once per frame tick, then runs a hit-flash and holds game over.
module flappy_collide #(
    parameter int BIRD_X       = 160,
    parameter int BIRD_W       = 16,
    parameter int BIRD_H       = 16,
    parameter int PIPE_W       = 40,
    parameter int GAP_H        = 120,
    parameter int GAP0         = 100,
    parameter int GAP1         = 180,
    parameter int GAP2         = 260,
    parameter int GAP3         = 140,
    parameter int FLOOR_Y      = 464,
    parameter int FLASH_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       count_EN,
    input  logic       frame_tick,
    input  logic [9:0] pipe_x,
    input  logic [1:0] out_pipe,
    input  logic [9:0] bird_y,
    output logic       Lose,
    output logic       flash,
    output logic [1:0] hit_cause
);

    localparam int CNT_W = $clog2(FLASH_FRAMES + 1);

    // 11-bit operands: 10-bit positions plus small constants never wrap.
    localparam logic [10:0] BIRD_X11  = 11'(BIRD_X);
    localparam logic [10:0] BIRD_W11  = 11'(BIRD_W);
    localparam logic [10:0] BIRD_H11  = 11'(BIRD_H);
    localparam logic [10:0] PIPE_W11  = 11'(PIPE_W);
    localparam logic [10:0] GAP_H11   = 11'(GAP_H);
    localparam logic [10:0] FLOOR_Y11 = 11'(FLOOR_Y);

    typedef enum logic [1:0] {IDLE, PLAY, HIT, DEAD} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             lose_n, flash_n;
    logic [1:0]       cause_n;

    logic [10:0] px, by, bird_bot, gap_top;
    logic        h_ovl, pipe_hit, floor_hit;

    always_comb begin
        case (out_pipe)
            2'd0:    gap_top = 11'(GAP0);
            2'd1:    gap_top = 11'(GAP1);
            2'd2:    gap_top = 11'(GAP2);
            default: gap_top = 11'(GAP3);
        endcase
    end

    assign px        = {1'b0, pipe_x};
    assign by        = {1'b0, bird_y};
    assign bird_bot  = by + BIRD_H11;
    assign h_ovl     = (px < BIRD_X11 + BIRD_W11) && (px + PIPE_W11 > BIRD_X11);
    assign pipe_hit  = h_ovl && ((by < gap_top) || (bird_bot > gap_top + GAP_H11));
    assign floor_hit = (bird_bot >= FLOOR_Y11);

    // NOTE: every next-value signal gets a default first so no latch is inferred.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lose_n  = Lose;
        flash_n = flash;
        cause_n = hit_cause;
        case (state)
            IDLE: begin
                if (count_EN) state_n = PLAY;
            end
            PLAY: begin
                if (!count_EN) begin
                    state_n = IDLE;
                end else if (frame_tick && (pipe_hit || floor_hit)) begin
                    state_n = HIT;
                    lose_n  = 1'b1;
                    cause_n = {floor_hit, pipe_hit};
                    cnt_n   = CNT_W'(FLASH_FRAMES);
                    flash_n = 1'b1;
                end
            end
            HIT: begin
                if (frame_tick) begin
                    cnt_n = cnt - CNT_W'(1);
                    // The final tick forces the blink off instead of toggling it.
                    if (cnt <= CNT_W'(1)) begin
                        state_n = DEAD;
                        flash_n = 1'b0;
                    end else begin
                        flash_n = ~flash;
                    end
                end
            end
            DEAD: ;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            Lose      <= 1'b0;
            flash     <= 1'b0;
            hit_cause <= 2'b00;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            Lose      <= lose_n;
            flash     <= flash_n;
            hit_cause <= cause_n;
        end
    end

endmodule
